// File: rtl/video_pkg.sv
// ============================================================================
// Module : video_pkg
// Desc   : Shared constants, state encoding and 1080p60 timing defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package video_pkg;

  localparam logic [15:0] YC_BLANK = 16'h1080;

  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_SOF = 2'd1;
  localparam logic [1:0] RUN      = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE     = IDLE,
    S_WAIT_SOF = WAIT_SOF,
    S_RUN      = RUN
  } state_e;

endpackage

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module : video_timing_gen
// Desc   : Free-running h/v raster counters with raw sync/active decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  output logic [11:0] h_cnt_o,
  output logic [11:0] v_cnt_o,
  output logic        hs_raw_o,
  output logic        vs_raw_o,
  output logic        de_raw_o,
  output logic        first_pix_o
);

  localparam logic [11:0] H_TOTAL     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] V_TOTAL     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] H_SYNC_END  = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_END  = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_START = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_ACT_END   = 12'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [11:0] V_ACT_START = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_ACT_END   = 12'(V_SYNC + V_BP + V_ACTIVE);

  logic [11:0] h_cnt_q, h_cnt_d;
  logic [11:0] v_cnt_q, v_cnt_d;
  logic        w_h_act;
  logic        w_v_act;

  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_TOTAL - 12'd1) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_TOTAL - 12'd1) ? '0 : v_cnt_q + 12'd1;
    end
    // Stopped raster parks at the origin so a restart begins a fresh frame.
    if (!run_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign w_h_act     = (h_cnt_q >= H_ACT_START) && (h_cnt_q < H_ACT_END);
  assign w_v_act     = (v_cnt_q >= V_ACT_START) && (v_cnt_q < V_ACT_END);

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign hs_raw_o    = (h_cnt_q < H_SYNC_END);
  assign vs_raw_o    = (v_cnt_q < V_SYNC_END);
  assign de_raw_o    = w_h_act && w_v_act;
  assign first_pix_o = w_h_act && w_v_act &&
                       (h_cnt_q == H_ACT_START) && (v_cnt_q == V_ACT_START);

endmodule

`default_nettype wire

// File: rtl/video_out_gen.sv
// ============================================================================
// Module : video_out_gen
// Desc   : Raster generator draining a YC pixel stream into the active area.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module video_out_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr_flags,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        vout_vs,
  output logic        vout_hs,
  output logic        vout_de,
  output logic [15:0] vout_yc,
  output logic        underflow,
  output logic        sof_err
);

  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);

  state_e      state_q, state_d;
  logic        w_run;
  logic        w_hs_raw;
  logic        w_vs_raw;
  logic        w_de_raw;
  logic        w_first_pix;
  logic        w_ready;
  logic        w_set_uf;
  logic        w_set_se;
  logic [15:0] yc_d;

  logic        vout_vs_q;
  logic        vout_hs_q;
  logic        vout_de_q;
  logic [15:0] vout_yc_q;
  logic        underflow_q;
  logic        sof_err_q;

  assign w_run = en && (state_q != S_IDLE);

  video_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .run_i       (w_run),
    .h_cnt_o     (),
    .v_cnt_o     (),
    .hs_raw_o    (w_hs_raw),
    .vs_raw_o    (w_vs_raw),
    .de_raw_o    (w_de_raw),
    .first_pix_o (w_first_pix)
  );

  always_comb begin
    state_d  = state_q;
    w_ready  = 1'b0;
    yc_d     = YC_BLANK;
    w_set_uf = 1'b0;
    w_set_se = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        // Flush stale words; hold an SOF word until the raster reaches it.
        w_ready = pix_valid && (!pix_sof || w_first_pix);
        if (w_first_pix && pix_valid && pix_sof) begin
          yc_d    = pix_data;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        w_ready = w_de_raw;
        if (w_de_raw) begin
          if (w_first_pix && !(pix_valid && pix_sof)) begin
            w_set_se = 1'b1;
            w_set_uf = !pix_valid;
            state_d  = S_WAIT_SOF;
          end else if (pix_valid) begin
            yc_d     = pix_data;
            w_set_se = pix_sof && !w_first_pix;
          end else begin
            w_set_uf = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (rst || !en) begin
      state_d  = S_IDLE;
      w_ready  = 1'b0;
      yc_d     = YC_BLANK;
      w_set_uf = 1'b0;
      w_set_se = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vout_vs_q   <= ~VS_ON;
      vout_hs_q   <= ~HS_ON;
      vout_de_q   <= 1'b0;
      vout_yc_q   <= YC_BLANK;
      underflow_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!en || state_q == S_IDLE) begin
        vout_vs_q <= ~VS_ON;
        vout_hs_q <= ~HS_ON;
        vout_de_q <= 1'b0;
        vout_yc_q <= YC_BLANK;
      end else begin
        vout_vs_q <= w_vs_raw ~^ VS_ON;
        vout_hs_q <= w_hs_raw ~^ HS_ON;
        vout_de_q <= w_de_raw;
        vout_yc_q <= yc_d;
      end
      // Flags stay sticky across enable drops; a same-cycle set beats clear.
      underflow_q <= w_set_uf || (underflow_q && !clr_flags);
      sof_err_q   <= w_set_se || (sof_err_q && !clr_flags);
    end
  end

  assign pix_ready = w_ready;
  assign vout_vs   = vout_vs_q;
  assign vout_hs   = vout_hs_q;
  assign vout_de   = vout_de_q;
  assign vout_yc   = vout_yc_q;
  assign underflow = underflow_q;
  assign sof_err   = sof_err_q;

endmodule

`default_nettype wire

// File: tb/tb_video_out_gen.sv
// ============================================================================
// Module : tb_video_out_gen
// Desc   : Randomized bench for video_out_gen against a raster-position model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_video_out_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam logic [15:0] BLK = 16'h1080;

  logic        clk = 1'b0;
  logic        rst, en, clr_flags, pix_valid, pix_sof;
  logic [15:0] pix_data;
  logic        pix_ready, vout_vs, vout_hs, vout_de, underflow, sof_err;
  logic [15:0] vout_yc;

  always #5 clk = ~clk;

  video_out_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (1),  .VS_POL (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_flags (clr_flags),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .vout_vs   (vout_vs),
    .vout_hs   (vout_hs),
    .vout_de   (vout_de),
    .vout_yc   (vout_yc),
    .underflow (underflow),
    .sof_err   (sof_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Source stream: {sof, data}; popped when the model says a word is taken.
  logic [16:0] src_q[$];
  logic [15:0] next_word = 16'h0000;

  // Model: mode 0 = stopped, 1 = hunting SOF, 2 = streaming; m_t = raster clock.
  int          m_mode = 0;
  int          m_t    = 0;
  logic        e_vs, e_hs, e_de, e_uf, e_se, e_ready;
  logic [15:0] e_yc;

  bit cnt_on = 1'b0;
  int hs_n = 0, vs_n = 0, de_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void raster(output bit hs, output bit vs, output bit de, output bit fp);
    int h, v;
    h  = m_t % HT;
    v  = m_t / HT;
    hs = (h < HS);
    vs = (v < VS);
    de = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    fp = de && (h == HS + HB) && (v == VS + VB);
  endfunction

  function automatic bit model_ready();
    bit hs, vs, de, fp;
    raster(hs, vs, de, fp);
    if (rst || !en || m_mode == 0) return 1'b0;
    if (m_mode == 1) return pix_valid && (!pix_sof || fp);
    return de;
  endfunction

  task automatic model_step();
    bit hs, vs, de, fp, set_uf, set_se;
    raster(hs, vs, de, fp);
    set_uf = 1'b0;
    set_se = 1'b0;
    if (rst) begin
      m_mode = 0; m_t = 0;
      e_vs = 0; e_hs = 0; e_de = 0; e_yc = BLK; e_uf = 0; e_se = 0;
      return;
    end
    if (!en || m_mode == 0) begin
      m_mode = en ? 1 : 0;
      m_t    = 0;
      e_vs = 0; e_hs = 0; e_de = 0; e_yc = BLK;
    end else begin
      e_hs = hs; e_vs = vs; e_de = de; e_yc = BLK;
      if (m_mode == 1) begin
        if (fp && pix_valid && pix_sof) begin
          e_yc   = pix_data;
          m_mode = 2;
        end
      end else if (de) begin
        if (fp && !(pix_valid && pix_sof)) begin
          set_se = 1; set_uf = !pix_valid; m_mode = 1;
        end else if (pix_valid) begin
          e_yc   = pix_data;
          set_se = pix_sof && !fp;
        end else begin
          set_uf = 1;
        end
      end
      m_t = (m_t + 1) % FT;
    end
    e_uf = set_uf ? 1'b1 : (clr_flags ? 1'b0 : e_uf);
    e_se = set_se ? 1'b1 : (clr_flags ? 1'b0 : e_se);
  endtask

  // One clock: drive at negedge, check ready, step model, check registered outputs.
  task automatic do_cycle(input bit r, input bit e, input bit c, input int vprob);
    rst = r; en = e; clr_flags = c;
    if (src_q.size() > 0 && $urandom_range(99) < vprob) begin
      pix_valid = 1'b1;
      pix_sof   = src_q[0][16];
      pix_data  = src_q[0][15:0];
    end else begin
      pix_valid = 1'b0;
      pix_sof   = 1'($urandom);
      pix_data  = 16'($urandom);
    end
    #1;
    e_ready = model_ready();
    check_eq("pix_ready", pix_ready, e_ready);
    model_step();
    if (e_ready && pix_valid) void'(src_q.pop_front());
    @(negedge clk);
    check_eq("vout_vs", vout_vs, e_vs);
    check_eq("vout_hs", vout_hs, e_hs);
    check_eq("vout_de", vout_de, e_de);
    check_eq("vout_yc", vout_yc, e_yc);
    check_eq("underflow", underflow, e_uf);
    check_eq("sof_err", sof_err, e_se);
    if (cnt_on) begin
      hs_n += int'(vout_hs);
      vs_n += int'(vout_vs);
      de_n += int'(vout_de);
    end
  endtask

  function automatic void push_frame(input bit good_sof, input int stray, input int junk);
    bit s;
    for (int i = 0; i < junk; i++) src_q.push_back({1'b0, 16'hA000 + 16'(i)});
    for (int i = 0; i < HA * VA; i++) begin
      s = (i == 0) ? good_sof : (i == stray);
      src_q.push_back({s, next_word});
      next_word = next_word + 16'd1;
    end
  endfunction

  function automatic int drop_mid_line3();
    int h, v;
    h = m_t % HT;
    v = m_t / HT;
    return (m_mode == 2 && v == 3 && h >= 6 && h < 9) ? 0 : 100;
  endfunction

  initial begin
    int en_off, vp;
    bit done;
    e_vs = 0; e_hs = 0; e_de = 0; e_yc = BLK; e_uf = 0; e_se = 0;
    rst = 1; en = 0; clr_flags = 0; pix_valid = 0; pix_sof = 0; pix_data = '0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) do_cycle(1, 0, 0, 0);

    // Free run with no stream; count sync/de per frame over a steady window.
    for (int i = 0; i < 2 * FT + 10; i++) begin
      cnt_on = (i >= 20 && i < 20 + FT);
      do_cycle(0, 1, 0, 0);
    end
    cnt_on = 1'b0;
    check_eq("hs_per_frame", 32'(hs_n), 32'(HS * VT));
    check_eq("vs_per_frame", 32'(vs_n), 32'(VS * HT));
    check_eq("de_per_frame", 32'(de_n), 32'(HA * VA));

    // Five junk words, then SOF 0x0000 with continuous words, then one more frame.
    push_frame(1, -1, 5);
    push_frame(1, -1, 0);
    for (int i = 0; i < 3 * FT; i++) do_cycle(0, 1, 0, 100);

    // Underflow: stall three active clocks on line 3, then clear.
    push_frame(1, -1, 0);
    push_frame(1, -1, 0);
    for (int i = 0; i < 2 * FT; i++) do_cycle(0, 1, 0, drop_mid_line3());
    do_cycle(0, 1, 1, 100);

    // Missing SOF at the frame head, then a good frame realigns.
    push_frame(0, -1, 0);
    push_frame(1, -1, 0);
    push_frame(1, -1, 0);
    for (int i = 0; i < 3 * FT; i++) do_cycle(0, 1, 0, 100);

    // Enable drop in the middle of line 2 for ten clocks.
    push_frame(1, -1, 0);
    done = 1'b0;
    for (int i = 0; i < 4 * FT; i++) begin
      if (!done && m_mode != 0 && m_t == 2 * HT + 5) begin
        for (int k = 0; k < 10; k++) do_cycle(0, 0, 0, 100);
        done = 1'b1;
      end
      do_cycle(0, 1, 0, 100);
    end
    check_eq("en_drop_seen", 32'(done), 32'd1);

    // Randomized traffic: gaps, bad SOFs, stray SOFs, clears, enable drops, resets.
    en_off = 0;
    vp     = 90;
    for (int k = 0; k < 2500; k++) begin
      if (src_q.size() < 40)
        push_frame($urandom_range(19) != 0,
                   ($urandom_range(19) == 0) ? int'($urandom_range(31, 1)) : -1,
                   ($urandom_range(4) == 0) ? int'($urandom_range(3, 1)) : 0);
      if (en_off > 0) en_off--;
      else if ($urandom_range(399) == 0) en_off = 10;
      if (k % 200 == 0) vp = int'($urandom_range(100, 70));
      do_cycle($urandom_range(799) == 0, en_off == 0, $urandom_range(49) == 0, vp);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/video_out_gen.md
Name: video_out_gen

Overview:
- Transmit-side counterpart of the video input matrix.
- Generates local raster timing (vs/hs/de) on one clock and drains a 16-bit YC pixel stream into the active region.
- Output format is the same vs/hs/de/yc format the matrix consumes.
- Handles SOF alignment and underflow by substituting black (Y=0x10, C=0x80).

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch (clocks)
- H_SYNC, 44, hsync width
- H_BP, 148, horizontal back porch
- V_ACTIVE, 1080, active lines
- V_FP, 4, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 36, vertical back porch
- HS_POL, 1, 1 = hsync active-high
- VS_POL, 1, 1 = vsync active-high

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous reset, active-high
- en  in  1  run enable
- clr_flags  in  1  one-cycle pulse; clears sticky flags
- pix_valid  in  1  stream word present
- pix_sof  in  1  word is first pixel of a frame
- pix_data  in  16  YC word, [15:8]=Y, [7:0]=C
- pix_ready  out  1  stream word consumed this cycle when pix_valid=1
- vout_vs  out  1  vertical sync
- vout_hs  out  1  horizontal sync
- vout_de  out  1  data enable
- vout_yc  out  16  pixel data
- underflow  out  1  sticky: active pixel with no valid word
- sof_err  out  1  sticky: frame start without SOF at stream head

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1 and wraps; v_cnt increments on h wrap and runs 0..V_TOTAL-1.
  - H_TOTAL = sum of the four H parameters; V_TOTAL likewise. Both counters are 12 bits.
- Sync and active decode:
  - hs_raw = h_cnt < H_SYNC.
  - vs_raw = v_cnt < V_SYNC; it changes only at h_cnt = 0.
  - de_raw = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - first_pix = de_raw at the first active line and first active column.
- Outputs are registered one cycle after counter decode:
  - vout_hs = hs_raw XNOR HS_POL.
  - vout_vs = vs_raw XNOR VS_POL.
  - vout_de = de_raw AND (state != IDLE).
- Reset values:
  - Counters 0; state IDLE.
  - vout_de = 0; vout_hs = ~HS_POL; vout_vs = ~VS_POL; vout_yc = 16'h1080.
  - underflow = 0; sof_err = 0.
- State machine:
  - IDLE: counters held at 0; pix_ready = 0; syncs inactive; yc = 16'h1080. If en=1 → WAIT_SOF next cycle, and counters start from 0.
  - WAIT_SOF: timing runs and vout_de toggles normally; vout_yc = 16'h1080 on every cycle.
    - pix_ready = pix_valid & ~pix_sof, so non-SOF words are flushed at one per clock.
    - At first_pix with pix_valid & pix_sof: consume the word, drive it on vout_yc next cycle, → RUN.
  - RUN: pix_ready = de_raw. On a de_raw cycle:
    - If pix_valid: vout_yc <= pix_data (1-cycle latency, aligned with vout_de).
    - If not pix_valid: vout_yc <= 16'h1080 and set underflow. No word is consumed, and the raster does not stall.
    - At first_pix, if the head is not (pix_valid & pix_sof): set sof_err, drive black, → WAIT_SOF. This realigns at the next frame.
    - A word with pix_sof=1 at any non-first_pix position: consumed as an ordinary pixel and sets sof_err; state stays RUN.
  - Outside de_raw, vout_yc = 16'h1080.
- en=0 in any state: next cycle → IDLE. Counters zero immediately; outputs go to their reset values; no partial-line completion.
- rst mid-frame: same as reset values; stream words are not consumed.
- Sticky flags:
  - clr_flags clears both flags.
  - A set and a clear in the same cycle: set wins.
- Parameters are assumed legal: every field ≥ 1 and totals ≤ 4095. No runtime check.

Decomposition:
- Shared package video_pkg holds:
  - YC_BLANK = 16'h1080.
  - 1080p60 default timing constants.
  - State encoding localparams IDLE=0, WAIT_SOF=1, RUN=2.
- Sub-module video_timing_gen (clk, rst, run) outputs h_cnt, v_cnt, hs_raw, vs_raw, de_raw, first_pix. The top adds the FSM, stream handshake and output registers.

Test Plan:
All scenarios use small timing: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1. This gives H_TOTAL=14, V_TOTAL=7 and a 98-clock frame.
- Free-run with pix_valid=0, en=1 from reset:
  - hs high 2 of every 14 clocks; vs high for 14 clocks per 98.
  - de 8 clocks on lines 2..5.
  - yc = 1080 throughout; underflow stays 0 while in WAIT_SOF.
- Continuous stream: SOF word 0x0000, then incrementing words up to 0x001F:
  - The first vout_de cycle of frame 1 carries 0x0000, one cycle after the first_pix counter value.
  - The 32 words appear in order.
  - underflow=0 and sof_err=0.
- Stream starts with 5 non-SOF words, then SOF:
  - The 5 words are flushed with pix_ready=1 during WAIT_SOF.
  - The SOF word appears on the first pixel of the next frame.
  - sof_err=0.
- In RUN, drop pix_valid for 3 active clocks mid-line 3:
  - Those 3 outputs are 1080 with de=1; underflow=1.
  - The next valid word appears on the next de cycle, and the raster timing is unchanged.
  - clr_flags then gives underflow=0.
- In RUN, present a non-SOF head at first_pix:
  - sof_err=1; state WAIT_SOF; the frame outputs 1080.
  - An SOF at the following frame restores RUN.
- Deassert en mid-line 2, reassert 10 clocks later:
  - Next cycle: de=0, hs=vs=0, yc=1080.
  - After reassertion, hs rises 1 cycle after en and the frame restarts at h=v=0.
